// File: rtl/mda_motor_control_cmd_sched.sv
// Command scheduler and slew-rate limiter feeding the per-motor PWM generators.
// Holds a target per motor, ramps live duty toward it on each tick, and drops all motors on host silence.
module mda_motor_control_cmd_sched #(
   parameter int NUM_MOTORS = 8,
   parameter int STEP       = 16,
   parameter int TICK_DIV   = 16000,
   parameter int WDOG_TICKS = 500
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [15:0]              period,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_motor,
   input  logic [15:0]              cmd_duty,
   input  logic                     cmd_on,
   output logic [NUM_MOTORS-1:0]    motor_on,
   output logic [16*NUM_MOTORS-1:0] motor_duty,
   output logic                     wdog_tripped,
   output logic                     busy
);

   localparam int IDX_W  = $clog2(NUM_MOTORS);
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int WD_W   = $clog2(WDOG_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [WD_W-1:0]   WD_SAT    = WD_W'(WDOG_TICKS);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WDOG_TICKS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_MOTORS - 1);
   localparam logic [16:0]       STEP17    = 17'(STEP);
   localparam logic [3:0]        NUM_M4    = 4'(NUM_MOTORS);

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               sweep_idx_q, sweep_idx_d;
   logic [TICK_W-1:0]              tick_cnt_q, tick_cnt_d;
   logic [WD_W-1:0]                wdog_cnt_q, wdog_cnt_d;
   logic                           wdog_tripped_q, wdog_tripped_d;
   logic [NUM_MOTORS-1:0]          on_q, on_d;
   logic [NUM_MOTORS-1:0][15:0]    live_q, live_d;
   logic [NUM_MOTORS-1:0][15:0]    target_q, target_d;
   logic [NUM_MOTORS-1:0][15:0]    ramp_val;

   logic [15:0] half;
   logic [15:0] cmd_target;
   logic        tick;
   logic        accept;
   logic        valid_accept;

   assign half         = {1'b0, period[15:1]};
   assign cmd_target   = (cmd_duty < period) ? cmd_duty : period;
   assign tick         = (tick_cnt_q == TICK_LAST);
   assign cmd_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q == ST_SWEEP);
   assign accept       = cmd_valid && cmd_ready;
   assign valid_accept = accept && ({1'b0, cmd_motor} < NUM_M4);

   // Per-motor slew step; 17-bit sums keep the clamp correct near 0 and 65535.
   for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ramp
      logic [16:0] up_sum;
      logic [16:0] dn_diff;
      logic [15:0] up_val;
      logic [15:0] dn_val;

      assign up_sum  = {1'b0, live_q[gi]} + STEP17;
      assign dn_diff = {1'b0, live_q[gi]} - STEP17;
      assign up_val  = (up_sum > {1'b0, target_q[gi]}) ? target_q[gi] : up_sum[15:0];
      assign dn_val  = (dn_diff[16] || (dn_diff[15:0] < target_q[gi])) ? target_q[gi]
                                                                        : dn_diff[15:0];
      assign ramp_val[gi] = !on_q[gi]                    ? live_q[gi] :
                            (live_q[gi] < target_q[gi])  ? up_val     :
                            (live_q[gi] > target_q[gi])  ? dn_val     : live_q[gi];
   end

   always_comb begin
      state_d        = state_q;
      sweep_idx_d    = sweep_idx_q;
      tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
      wdog_cnt_d     = wdog_cnt_q;
      wdog_tripped_d = wdog_tripped_q;
      on_d           = on_q;
      live_d         = live_q;
      target_d       = target_q;

      if (state_q == ST_IDLE) begin
         if (tick) begin
            state_d     = ST_SWEEP;
            sweep_idx_d = '0;
         end
      end else begin
         for (int m = 0; m < NUM_MOTORS; m++) begin
            if (sweep_idx_q == IDX_W'(m)) begin
               live_d[m] = ramp_val[m];
            end
         end
         if (sweep_idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
         end else begin
            sweep_idx_d = sweep_idx_q + 1'b1;
         end
      end

      // Accepts only happen in IDLE, so they never collide with a sweep update.
      if (valid_accept) begin
         wdog_cnt_d     = '0;
         wdog_tripped_d = 1'b0;
         for (int m = 0; m < NUM_MOTORS; m++) begin
            if (cmd_motor == 3'(m)) begin
               if (!cmd_on) begin
                  on_d[m]     = 1'b0;
                  live_d[m]   = half;
                  target_d[m] = half;
               end else begin
                  if (!on_q[m]) begin
                     on_d[m]   = 1'b1;
                     live_d[m] = half;
                  end
                  target_d[m] = cmd_target;
               end
            end
         end
      end else if (tick && (wdog_cnt_q != WD_SAT)) begin
         wdog_cnt_d = wdog_cnt_q + 1'b1;
         if (wdog_cnt_q == WD_LAST) begin
            wdog_tripped_d = 1'b1;
            on_d           = '0;
            for (int m = 0; m < NUM_MOTORS; m++) begin
               live_d[m]   = half;
               target_d[m] = half;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         sweep_idx_q    <= '0;
         tick_cnt_q     <= '0;
         wdog_cnt_q     <= '0;
         wdog_tripped_q <= 1'b0;
         on_q           <= '0;
         live_q         <= '0;
         target_q       <= '0;
      end else begin
         state_q        <= state_d;
         sweep_idx_q    <= sweep_idx_d;
         tick_cnt_q     <= tick_cnt_d;
         wdog_cnt_q     <= wdog_cnt_d;
         wdog_tripped_q <= wdog_tripped_d;
         on_q           <= on_d;
         live_q         <= live_d;
         target_q       <= target_d;
      end
   end

   assign motor_on     = on_q;
   assign motor_duty   = live_q;
   assign wdog_tripped = wdog_tripped_q;

endmodule

// File: tb/tb_mda_motor_control_cmd_sched.sv
// Directed bench for the motor command scheduler: ramping, clamping, watchdog and reset behaviour.
module tb_mda_motor_control_cmd_sched;

   localparam int NM = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [15:0]      period = 16'd1000;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_motor = 3'd0;
   logic [15:0]      cmd_duty = 16'd0;
   logic             cmd_on = 1'b0;
   logic [NM-1:0]    motor_on;
   logic [16*NM-1:0] motor_duty;
   logic             wdog_tripped;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   mda_motor_control_cmd_sched #(
      .NUM_MOTORS (NM),
      .STEP       (16),
      .TICK_DIV   (20),
      .WDOG_TICKS (5)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .period       (period),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_motor    (cmd_motor),
      .cmd_duty     (cmd_duty),
      .cmd_on       (cmd_on),
      .motor_on     (motor_on),
      .motor_duty   (motor_duty),
      .wdog_tripped (wdog_tripped),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] duty(input int i);
      return motor_duty[16*i +: 16];
   endfunction

   task automatic wait_busy(input logic level);
      int n = 0;
      @(negedge clk);
      while (busy !== level && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy !== level) check("busy_timeout", {63'd0, busy}, {63'd0, level});
   endtask

   task automatic wait_sweep();
      wait_busy(1'b1);
      wait_busy(1'b0);
   endtask

   task automatic send_cmd(input logic [2:0] m, input logic on, input logic [15:0] d);
      logic ok = 1'b0;
      @(negedge clk);
      cmd_motor = m;
      cmd_on    = on;
      cmd_duty  = d;
      cmd_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      $display("cmd motor=%0d on=%0d duty=%0d accepted=%0d", m, on, d, ok);
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int exp;
      int lows;
      int n;

      // Reset values
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_motor_on", motor_on, 0);
      check("rst_duty", motor_duty, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_wdog", wdog_tripped, 0);

      // Motor 1 ramps 500 -> 600
      send_cmd(3'd1, 1'b1, 16'd600);
      check("m1_on", motor_on, 4'b0010);
      check("m1_start", duty(1), 500);
      for (int k = 1; k <= 7; k++) begin
         wait_sweep();
         exp = (500 + 16*k > 600) ? 600 : 500 + 16*k;
         check("m1_ramp", duty(1), exp);
         send_cmd(3'd1, 1'b1, 16'd600);
      end
      wait_sweep();
      check("m1_hold", duty(1), 600);

      // Motor 2 clamps to period, then descends to 0
      send_cmd(3'd2, 1'b1, 16'd1200);
      check("m2_on", motor_on, 4'b0110);
      check("m2_start", duty(2), 500);
      for (int k = 1; k <= 32; k++) begin
         wait_sweep();
         exp = (500 + 16*k > 1000) ? 1000 : 500 + 16*k;
         check("m2_up", duty(2), exp);
         send_cmd(3'd2, 1'b1, 16'd1200);
      end
      wait_sweep();
      check("m2_clamp_hold", duty(2), 1000);
      send_cmd(3'd2, 1'b1, 16'd0);
      check("m2_live_kept", duty(2), 1000);
      for (int k = 1; k <= 63; k++) begin
         wait_sweep();
         exp = (1000 - 16*k < 0) ? 0 : 1000 - 16*k;
         check("m2_down", duty(2), exp);
         send_cmd(3'd2, 1'b1, 16'd0);
      end
      wait_sweep();
      check("m2_floor_hold", duty(2), 0);
      check("m1_untouched", duty(1), 600);

      // Motor 1 off during a descending ramp
      send_cmd(3'd1, 1'b1, 16'd200);
      wait_sweep();
      check("m1_desc1", duty(1), 584);
      send_cmd(3'd1, 1'b1, 16'd200);
      wait_sweep();
      check("m1_desc2", duty(1), 568);
      send_cmd(3'd1, 1'b0, 16'd123);
      check("m1_off", motor_on, 4'b0100);
      check("m1_off_half", duty(1), 500);
      wait_sweep();
      check("m1_off_stay1", duty(1), 500);
      send_cmd(3'd2, 1'b1, 16'd0);
      wait_sweep();
      check("m1_off_stay2", duty(1), 500);

      // Command held across a tick
      wait_busy(1'b1);
      cmd_motor = 3'd3;
      cmd_on    = 1'b1;
      cmd_duty  = 16'd300;
      cmd_valid = 1'b1;
      lows = 0;
      while (!cmd_ready && lows < 20) begin
         lows++;
         @(negedge clk);
      end
      check("ready_low_cycles", lows, 4);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      $display("cmd motor=3 on=1 duty=300 held across tick");
      check("m3_on", motor_on, 4'b1100);
      check("m3_start", duty(3), 500);
      wait_sweep();
      check("m3_desc", duty(3), 484);

      // Watchdog: five silent ticks
      send_cmd(3'd2, 1'b1, 16'd0);
      for (int t = 1; t <= 4; t++) begin
         wait_sweep();
         check("wdog_not_yet", wdog_tripped, 0);
      end
      check("m3_before_trip", duty(3), 420);
      check("on_before_trip", motor_on, 4'b1100);
      wait_sweep();
      check("wdog_trip", wdog_tripped, 1);
      check("trip_all_off", motor_on, 0);
      for (int i = 0; i < NM; i++) check("trip_half", duty(i), 500);
      send_cmd(3'd5, 1'b1, 16'd700);
      check("bad_idx_wdog", wdog_tripped, 1);
      check("bad_idx_on", motor_on, 0);
      send_cmd(3'd0, 1'b1, 16'd700);
      check("wdog_clear", wdog_tripped, 0);
      check("m0_on", motor_on, 4'b0001);
      check("m0_start", duty(0), 500);
      wait_sweep();
      check("m0_ramp", duty(0), 516);

      // Reset in sweep cycle 2
      wait_busy(1'b1);
      @(negedge clk);
      @(negedge clk);
      check("mid_sweep_busy", busy, 1);
      check("mid_sweep_m0", duty(0), 532);
      reset_n = 1'b0;
      #1;
      check("arst_on", motor_on, 0);
      check("arst_duty", motor_duty, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", cmd_ready, 1);
      check("arst_wdog", wdog_tripped, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy) begin
            n = c;
            break;
         end
      end
      check("restart_first_tick", n, 20);
      wait_busy(1'b0);
      check("restart_duty", motor_duty, 0);
      check("restart_on", motor_on, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
